// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - two-requester round-robin byte FIFO feeding a UART transmitter with fixed byte spacing
// The transmitter has no busy output, so bytes are released as one-cycle
// strobes separated by a byte-time counter rather than by a handshake.
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int BYTE_CYCLES = 9600,
  parameter int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          sys_clk_i,
  input  logic          sys_rstn_i,
  input  logic          req0_valid_i,
  input  logic [7:0]    req0_data_i,
  output logic          req0_ready_o,
  input  logic          req1_valid_i,
  input  logic [7:0]    req1_data_i,
  output logic          req1_ready_o,
  input  logic          enable_i,
  output logic          uart_wr_o,
  output logic [7:0]    uart_dat_o,
  output logic [CW-1:0] fifo_count_o,
  output logic          idle_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(BYTE_CYCLES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_last;
  state_t        r_state;
  logic [TW-1:0] r_cnt;
  logic          r_uart_wr;
  logic [7:0]    r_uart_dat;

  logic          w_grant0;
  logic          w_grant1;
  logic          w_not_full;
  logic          w_push;
  logic [7:0]    w_push_data;
  logic          w_slot;
  logic          w_pop;

  // A lone requester wins; under contention the one not served last wins.
  assign w_grant0     = req0_valid_i & (~req1_valid_i | r_last);
  assign w_grant1     = req1_valid_i & (~req0_valid_i | ~r_last);
  // Fullness uses the current count only, so a same-edge pop never frees a slot early.
  assign w_not_full   = (r_count < CW'(FIFO_DEPTH));
  assign req0_ready_o = w_grant0 & w_not_full & sys_rstn_i;
  assign req1_ready_o = w_grant1 & w_not_full & sys_rstn_i;
  assign w_push       = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);
  assign w_push_data  = w_grant0 ? req0_data_i : req1_data_i;

  // A byte may go out from IDLE, or from WAIT once the byte time has elapsed.
  assign w_slot = (r_state == S_IDLE) | (r_cnt == '0);
  assign w_pop  = w_slot & enable_i & (r_count != '0);

  assign uart_wr_o    = r_uart_wr;
  assign uart_dat_o   = r_uart_dat;
  assign fifo_count_o = r_count;
  assign idle_o       = (r_state == S_IDLE) & (r_count == '0);

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge sys_clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Remember which requester was served last for the round-robin decision.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_last <= 1'b0;
    end else if (req0_valid_i & req0_ready_o) begin
      r_last <= 1'b0;
    end else if (req1_valid_i & req1_ready_o) begin
      r_last <= 1'b1;
    end
  end

  // Issue sequencer: strobe a byte, then count down one byte time before the next.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_uart_wr  <= 1'b0;
      r_uart_dat <= 8'h00;
    end else begin
      r_uart_wr <= 1'b0;
      if (w_pop) begin
        r_uart_wr  <= 1'b1;
        r_uart_dat <= r_mem[r_rptr];
        r_cnt      <= TW'(BYTE_CYCLES - 1);
        r_state    <= S_WAIT;
      end else if (r_state == S_WAIT) begin
        if (r_cnt != '0) r_cnt <= r_cnt - TW'(1);
        else             r_state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl with a queue/timestamp reference model
module tb_uart_tx_ctrl;

  localparam int DEPTH = 16;
  localparam int BC    = 20;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          v0, v1, en;
  logic [7:0]    d0, d1;
  logic          r0, r1, wr, idle;
  logic [7:0]    dat;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  uart_tx_ctrl #(.FIFO_DEPTH(DEPTH), .BYTE_CYCLES(BC), .CW(CW)) dut (
    .sys_clk_i    (clk),
    .sys_rstn_i   (rstn),
    .req0_valid_i (v0),
    .req0_data_i  (d0),
    .req0_ready_o (r0),
    .req1_valid_i (v1),
    .req1_data_i  (d1),
    .req1_ready_o (r1),
    .enable_i     (en),
    .uart_wr_o    (wr),
    .uart_dat_o   (dat),
    .fifo_count_o (cnt),
    .idle_o       (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending bytes, time of last strobe, last served requester.
  logic [7:0] q[$];
  logic [7:0] s_dat[$];
  int         s_cyc[$];
  logic [7:0] acc[$];
  bit         m_last = 1'b0;
  int         li = -1000000;
  int         e = 0;
  logic       m_wr = 1'b0;
  logic [7:0] m_dat = 8'h00;

  always begin
    bit g0, g1, full, er0, er1, pop, ewait;
    @(negedge clk);
    #4;
    if (!rstn) begin
      q.delete();
      m_last = 1'b0;
      li     = -1000000;
      m_wr   = 1'b0;
      m_dat  = 8'h00;
    end
    g0    = v0 && (!v1 || m_last);
    g1    = v1 && (!v0 || !m_last);
    full  = (q.size() >= DEPTH);
    er0   = rstn && g0 && !full;
    er1   = rstn && g1 && !full;
    ewait = (e < li + BC);
    chk("model_wr", wr, m_wr);
    chk("model_dat", dat, m_dat);
    chk("model_count", cnt, q.size());
    chk("model_idle", idle, (!ewait && q.size() == 0));
    chk("model_ready0", r0, er0);
    chk("model_ready1", r1, er1);
    if (wr) begin
      s_dat.push_back(dat);
      s_cyc.push_back(e);
    end
    if (v0 && r0) acc.push_back(d0);
    if (v1 && r1) acc.push_back(d1);
    if (rstn) begin
      pop = en && (q.size() > 0) && (e + 1 >= li + BC);
      if (pop) begin
        m_dat = q.pop_front();
        m_wr  = 1'b1;
        li    = e + 1;
      end else begin
        m_wr = 1'b0;
      end
      if (er0 && v0) begin
        q.push_back(d0);
        m_last = 1'b0;
      end else if (er1 && v1) begin
        q.push_back(d1);
        m_last = 1'b1;
      end
    end
    e++;
  end

  task automatic wait_idle(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #3;
      if (idle) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", ok, 1'b1);
  endtask

  task automatic single_byte(input logic [7:0] b, input string tag);
    @(negedge clk); v0 = 1'b1; d0 = b; #3;
    chk({tag, "_ready0"}, r0, 1'b1);
    @(negedge clk); v0 = 1'b0; #3;
    chk({tag, "_count_E"}, cnt, 1);
    chk({tag, "_wr_E"}, wr, 1'b0);
    @(negedge clk); #3;
    chk({tag, "_wr_E1"}, wr, 1'b1);
    chk({tag, "_dat_E1"}, dat, b);
    chk({tag, "_count_E1"}, cnt, 0);
    @(negedge clk); #3;
    chk({tag, "_wr_E2"}, wr, 1'b0);
    chk({tag, "_dat_hold"}, dat, b);
    wait_idle(100);
  endtask

  initial begin
    int base, abase, sbase, peak, a, b, idx;
    bit h0, h1;
    logic [7:0] rr_exp [12];
    rr_exp = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
    rstn = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00; en = 1'b0;

    // Reset values with a requester already valid
    repeat (3) @(negedge clk);
    v0 = 1'b1; d0 = 8'h41; en = 1'b1; #3;
    chk("rst_wr", wr, 1'b0);
    chk("rst_dat", dat, 8'h00);
    chk("rst_count", cnt, 0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_ready0", r0, 1'b0);

    // Single byte 0x41: ready on release, strobe exactly one cycle after the push edge
    @(negedge clk); rstn = 1'b1; #3;
    chk("ready0_after_rst", r0, 1'b1);
    @(negedge clk); v0 = 1'b0; #3;
    chk("single_count_E", cnt, 1);
    chk("single_wr_E", wr, 1'b0);
    @(negedge clk); #3;
    chk("single_wr_E1", wr, 1'b1);
    chk("single_dat_E1", dat, 8'h41);
    chk("single_count_E1", cnt, 0);
    @(negedge clk); #3;
    chk("single_wr_E2", wr, 1'b0);
    wait_idle(100);

    // Burst of five bytes: spacing, order, peak occupancy
    base = s_dat.size();
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); v0 = 1'b1; d0 = 8'h10 + 8'(i); #3;
      if (cnt > peak) peak = cnt;
    end
    @(negedge clk); v0 = 1'b0; #3;
    if (cnt > peak) peak = cnt;
    wait_idle(200);
    chk("burst_peak", peak, 4);
    chk("burst_strobes", s_dat.size() - base, 5);
    if (s_dat.size() - base == 5) begin
      for (int i = 0; i < 5; i++) chk("burst_byte", s_dat[base+i], 8'h10 + 8'(i));
      for (int i = 1; i < 5; i++) chk("burst_spacing", s_cyc[base+i] - s_cyc[base+i-1], BC);
    end
    chk("burst_count_end", cnt, 0);

    // Requester 1 alone, then both contending
    abase = acc.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); v1 = 1'b1; d1 = 8'hC0 + 8'(i); #3;
      chk("req1_alone_ready", r1, 1'b1);
    end
    a = 0; b = 0;
    @(negedge clk); v0 = 1'b1; v1 = 1'b1; d0 = 8'hA0; d1 = 8'hB0;
    for (int k = 0; k < 30 && (a + b) < 8; k++) begin
      #3;
      h0 = v0 && r0;
      h1 = v1 && r1;
      @(negedge clk);
      if (h0) a++;
      if (h1) b++;
      d0 = 8'hA0 + 8'(a);
      d1 = 8'hB0 + 8'(b);
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("rr_accepted", acc.size() - abase, 12);
    if (acc.size() - abase == 12)
      for (int i = 0; i < 12; i++) chk("rr_order", acc[abase+i], rr_exp[i]);
    wait_idle(400);

    // Fill to full with the sequencer disabled, then drain and wrap the pointers over 40 bytes
    en = 1'b0; idx = 0; sbase = s_dat.size();
    @(negedge clk); v0 = 1'b1; d0 = 8'h00;
    for (int k = 0; k < 40; k++) begin
      #3;
      if (cnt == DEPTH) break;
      h0 = r0;
      @(negedge clk);
      if (h0) idx++;
      d0 = 8'(idx);
    end
    chk("full_count", cnt, DEPTH);
    chk("full_ready0", r0, 1'b0);
    chk("full_accepted", idx, DEPTH);
    repeat (2) begin
      @(negedge clk); #3;
      chk("full_hold_count", cnt, DEPTH);
      chk("full_hold_ready0", r0, 1'b0);
    end
    @(negedge clk); en = 1'b1; #3;
    chk("full_en_ready0", r0, 1'b0);
    @(negedge clk); #3;
    chk("full_pop_count", cnt, DEPTH - 1);
    chk("full_pop_wr", wr, 1'b1);
    chk("full_pop_dat", dat, 8'h00);
    chk("full_ready_back", r0, 1'b1);
    for (int k = 0; k < 2000 && idx < 40; k++) begin
      h0 = r0;
      @(negedge clk);
      if (h0) idx++;
      d0 = 8'(idx);
      #3;
    end
    v0 = 1'b0;
    chk("wrap_accepted", idx, 40);
    wait_idle(1500);
    chk("wrap_strobes", s_dat.size() - sbase, 40);
    if (s_dat.size() - sbase == 40)
      for (int i = 0; i < 40; i++) chk("wrap_order", s_dat[sbase+i], 8'(i));

    // Reset halfway through WAIT with six bytes queued
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); v0 = 1'b1; d0 = 8'h60 + 8'(i);
    end
    @(negedge clk); v0 = 1'b0; #3;
    chk("mid_queued", cnt, 6);
    repeat (4) @(negedge clk);
    #3;
    chk("mid_queued_hold", cnt, 6);
    @(negedge clk); rstn = 1'b0; #1;
    chk("mid_rst_count", cnt, 0);
    chk("mid_rst_wr", wr, 1'b0);
    chk("mid_rst_idle", idle, 1'b1);
    repeat (2) @(negedge clk);
    rstn = 1'b1; #3;
    sbase = s_dat.size();
    repeat (50) @(negedge clk);
    #3;
    chk("no_strobe_after_rst", s_dat.size() - sbase, 0);
    chk("count_after_rst", cnt, 0);
    single_byte(8'h5A, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
